// File: rtl/byte_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// byte_serial_add_ctrl_pkg
//   Shared definitions for the byte-serial adder sequencer.
//   - BYTE_W : width of the shared adder slice (one byte).
//   - state_t: sequencer state codes (IDLE=0, RUN=1, DONE=2).
//   Imported by byte_serial_add_ctrl and eightbitadder.
// -----------------------------------------------------------------------------
package byte_serial_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : byte_serial_add_ctrl_pkg

// File: rtl/byte_serial_add_ctrl_eightbitadder.sv
// -----------------------------------------------------------------------------
// eightbitadder
//   Plain 8-bit ripple-carry adder shared by the byte-serial sequencer.
//   Purely combinational.
// Ports:
//   a  [7:0] in   addend byte (bit 0 = LSB)
//   b  [7:0] in   addend byte (bit 0 = LSB)
//   ci       in   carry in to bit 0
//   s  [7:0] out  sum byte
//   co       out  carry out of bit 7
// -----------------------------------------------------------------------------
module eightbitadder
    import byte_serial_add_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    // c[i] is the carry into bit i; c[BYTE_W] is the carry out.
    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[BYTE_W];

endmodule : eightbitadder

// File: rtl/byte_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serial_add_ctrl
//   Sequences one shared 8-bit ripple-carry adder to add two NBYTES-wide
//   operands byte-serially, LSB byte first, one byte per clock. The carry
//   between bytes is held in a flop.
//
// Parameters:
//   NBYTES     operand width in bytes (>= 2); W = 8*NBYTES
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   request; sampled only in IDLE or DONE
//   a   [W]    in   operand A, captured on accepted start
//   b   [W]    in   operand B, captured on accepted start
//   cin        in   carry into byte 0, captured on accepted start
//   busy       out  high while bytes are being processed (RUN)
//   done       out  one-cycle pulse; sum/cout valid
//   sum [W]    out  result, held from done until the next accepted start
//   cout       out  carry out of the top byte, held like sum
//   sub        in   (SUBTRACT_EN only) 1 = compute a - b
//   fsm_state  out  current sequencer state, for observation
//
// Handshake: a request is accepted on any rising clock edge where start=1
//   and the sequencer is in IDLE or DONE. Requests in RUN are dropped, not
//   queued. done is asserted for exactly one cycle NBYTES+1 cycles after
//   the accepting edge's cycle; sum/cout are only meaningful from done on.
//
// Configuration macro:
//   SUBTRACT_EN  adds the 'sub' input. With sub=1 the B operand is inverted
//                on capture and the initial carry is forced to 1, giving
//                a - b; cout=1 then means "no borrow".
// -----------------------------------------------------------------------------
module byte_serial_add_ctrl
    import byte_serial_add_ctrl_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
`ifdef SUBTRACT_EN
    input  logic         sub,
`endif
    output state_t       fsm_state
);

    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;

    logic             accept;
    logic             last_byte;
    logic [W-1:0]     b_cap;
    logic             cin_cap;
    logic [BYTE_W-1:0] add_s;
    logic             add_co;

    // ------------------------------------------------------------------
    // Capture values. For subtraction B is inverted once at capture time
    // so the RUN datapath is identical for add and subtract.
    // ------------------------------------------------------------------
    always_comb begin
        b_cap   = b;
        cin_cap = cin;
`ifdef SUBTRACT_EN
        if (sub) begin
            b_cap   = ~b;
            cin_cap = 1'b1;
        end
`endif
    end

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_byte = (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // Shared adder: always looks at the low byte of the operand shift
    // registers and the carry flop.
    // ------------------------------------------------------------------
    eightbitadder u_adder (
        .a  (a_q[BYTE_W-1:0]),
        .b  (b_q[BYTE_W-1:0]),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_byte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Back-to-back request skips IDLE entirely.
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, byte shifting, carry and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_q     <= a;
            b_q     <= b_cap;
            carry_q <= cin_cap;
        end else if (state_q == RUN) begin
            // Result bytes enter at the MSB end; after NBYTES shifts byte 0
            // has travelled down to the bottom of sum.
            sum_q   <= {add_s, sum_q[W-1:BYTE_W]};
            carry_q <= add_co;
            a_q     <= a_q >> BYTE_W;
            b_q     <= b_q >> BYTE_W;
            if (last_byte) begin
                cnt_q  <= '0;
                cout_q <= add_co;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    // Outputs are either registers or decodes of the state register.
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign fsm_state = state_q;

endmodule : byte_serial_add_ctrl

// File: tb/tb_byte_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_add_ctrl
//   Directed self-checking bench for byte_serial_add_ctrl with NBYTES=4.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a period away from the active rising edge.
//   Define SUBTRACT_EN for both DUT and bench to exercise subtraction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_byte_serial_add_ctrl;
    import byte_serial_add_ctrl_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int TIMEOUT_CYCLES = 20;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         sub;
    state_t       fsm_state;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
`ifdef SUBTRACT_EN
        .sub       (sub),
`endif
        .fsm_state (fsm_state)
    );

    // ------------------------------------------------------------------
    // Driver: issue one request from IDLE and wait (bounded) for done.
    // On return we sit at the falling edge of the done cycle.
    // lat = cycle index of done counting the accepting cycle as 0.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, output int lat, output logic ok);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        vectors++;
        if ({busy, done, cout} !== 3'b000 || sum !== '0 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b state=%0d, expected 0/0/0/0/IDLE",
                     busy, done, sum, cout, fsm_state);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (fsm_state !== IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: state=%0d busy=%b, expected IDLE/0", fsm_state, busy);
        end
    endtask

    // FFFFFFFF + 1: carry must ripple through every byte; exact cycle timing.
    task automatic test_carry_ripple();
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= NBYTES; c++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL ripple_busy_cycle%0d: busy=%b done=%b, expected 1/0", c, busy, done);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ripple_done_cycle5: done=%b busy=%b, expected 1/0", done, busy);
        end
        vectors++;
        if (sum !== 32'h0000_0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_result: sum=%h cout=%b, expected 00000000/1", sum, cout);
        end
    endtask

    // Carry-in used, done exactly one cycle wide, result held afterwards.
    task automatic test_cin_and_pulse();
        int   lat;
        logic ok;
        @(negedge clk);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, lat, ok);
        vectors++;
        if (!ok || lat != 5) begin
            errors++;
            $display("FAIL cin_latency: ok=%b done_cycle=%0d, expected 1/5", ok, lat);
        end
        vectors++;
        if (sum !== 32'h2345_678A || cout !== 1'b0) begin
            errors++;
            $display("FAIL cin_result: sum=%h cout=%b, expected 2345678a/0", sum, cout);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL done_width: done=%b state=%0d one cycle later, expected 0/IDLE", done, fsm_state);
        end
        vectors++;
        if (sum !== 32'h2345_678A || cout !== 1'b0) begin
            errors++;
            $display("FAIL result_hold: sum=%h cout=%b, expected 2345678a/0", sum, cout);
        end
    endtask

    // Further hand-computed additions.
    task automatic test_add_vectors();
        logic [W-1:0] va [4] = '{32'h0000_0000, 32'h8000_0000, 32'h00FF_00FF, 32'hDEAD_BEEF};
        logic [W-1:0] vb [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0001_0001, 32'h2152_4110};
        logic         vc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0100_0100, 32'h0000_0000};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   lat;
        logic ok;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], lat, ok);
            vectors++;
            if (!ok || lat != 5 || sum !== es[i] || cout !== ec[i]) begin
                errors++;
                $display("FAIL add_vec%0d: ok=%b cycle=%0d sum=%h cout=%b, expected 1/5/%h/%b",
                         i, ok, lat, sum, cout, es[i], ec[i]);
            end
        end
    endtask

    // start held through RUN with new operands: ignored, then accepted in DONE.
    task automatic test_back_to_back();
        @(negedge clk);
        a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 32'h8000_0001; b = 32'h8000_0002;   // start stays high
        for (int c = 1; c <= NBYTES; c++) begin
            vectors++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first_busy_cycle%0d: busy=%b, expected 1", c, busy);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || sum !== 32'h0000_0100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_result: done=%b sum=%h cout=%b, expected 1/00000100/0", done, sum, cout);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle_gap: busy=%b done=%b, expected 1/0", busy, done);
        end
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_early_done_cycle%0d: done=%b, expected 0", c, done);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || sum !== 32'h0000_0003 || cout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_result: done=%b sum=%h cout=%b, expected 1/00000003/1", done, sum, cout);
        end
    endtask

    // Asynchronous reset in RUN cycle 2: immediate clear, no done afterwards.
    task automatic test_reset_abort();
        logic saw_done;
        @(negedge clk);
        a = 32'h1111_1110; b = 32'h2222_2220; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;   // RUN cycle 1
        @(negedge clk); // RUN cycle 2
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, cout} !== 3'b000 || sum !== '0 || fsm_state !== IDLE) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b sum=%h cout=%b state=%0d, expected 0/0/0/0/IDLE",
                     busy, done, sum, cout, fsm_state);
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: activity seen=%b after abort, expected 0", saw_done);
        end
    endtask

`ifdef SUBTRACT_EN
    task automatic test_subtract();
        int   lat;
        logic ok;
        sub = 1'b1;
        run_op(32'd5, 32'd7, 1'b0, lat, ok);
        vectors++;
        if (!ok || sum !== 32'hFFFF_FFFE || cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: ok=%b sum=%h cout=%b, expected 1/fffffffe/0", ok, sum, cout);
        end
        run_op(32'd7, 32'd5, 1'b0, lat, ok);
        vectors++;
        if (!ok || sum !== 32'd2 || cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_no_borrow: ok=%b sum=%h cout=%b, expected 1/00000002/1", ok, sum, cout);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_ripple();
        test_cin_and_pulse();
        test_add_vectors();
        test_back_to_back();
        test_reset_abort();
`ifdef SUBTRACT_EN
        test_subtract();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_byte_serial_add_ctrl
